usb_bulk_out_sched: RTL and testbench
=====================================

# usb_bulk_out_sched

Scheduler for a group of bulk OUT endpoints sharing one USB packet decoder. Each OUT token is decoded to an endpoint index and sequenced through data reception and handshake selection (ACK/NAK/STALL). The block drives each endpoint's select, error and ack-sent strobes, routes the decoder byte stream to the selected endpoint, and checks DATA0/DATA1 parity. It sits between the ULPI/USB packet decoder and handshake encoder on one side and N bulk OUT endpoints on the other.

## Interface
- NUM_EPS, 2: number of OUT endpoints served (1..15)
- EP_BASE, 1: USB endpoint number of index 0; endpoints are EP_BASE..EP_BASE+NUM_EPS-1
- TIMEOUT, 64: cycles to wait for a DATAx PID after the token
- Derived: IBITS = max(1, clog2(NUM_EPS)); TBITS = clog2(TIMEOUT+1)

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- tok_recv_i  in  1  one-cycle pulse: valid OUT token for this device
- tok_ep_i  in  4  token endpoint number, valid with tok_recv_i
- rx_start_i  in  1  one-cycle pulse: DATAx PID received
- rx_par_i  in  1  data PID parity (0=DATA0, 1=DATA1), valid with rx_start_i
- rx_done_i  in  1  pulse: packet ended with CRC16 OK
- rx_err_i  in  1  pulse: CRC16 error or receive timeout
- rx_tvalid, rx_tkeep, rx_tlast  in  1 each; rx_tdata  in  8; rx_tready  out  1: decoder byte stream
- ep_tvalid_o, ep_tkeep_o, ep_tlast_o  out  1 each; ep_tdata_o  out  8: stream broadcast to endpoints
- ep_tready_i  in  NUM_EPS  per-endpoint ready
- ep_ready_i, ep_stall_i, ep_par_i  in  NUM_EPS each  per-endpoint ready / stalled / expected parity
- ep_sel_o, ep_err_o, ep_ack_o  out  NUM_EPS each  select level, rx-error pulse, ack-sent pulse
- hsk_send_o  out  1  handshake request, held until hsk_done_i
- hsk_pid_o  out  2  0=ACK, 1=NAK, 2=STALL; stable while hsk_send_o is high
- hsk_done_i  in  1  one-cycle pulse: handshake transmitted
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT, RECV, SINK, HSK, DONE.
- IDLE: on tok_recv_i with tok_ep_i in range, latch idx = tok_ep_i - EP_BASE, clear the timeout counter and go to WAIT. Out-of-range tokens are ignored.
- WAIT: the counter increments each cycle. At TIMEOUT with no rx_start_i, return to IDLE with no handshake. On rx_start_i, decide in priority order:
  - ep_stall_i[idx] -> SINK, pid=STALL
  - !ep_ready_i[idx] -> SINK, pid=NAK
  - rx_par_i != ep_par_i[idx] (duplicate packet) -> SINK, pid=ACK, no endpoint ack
  - otherwise -> RECV, pid=ACK
- RECV: ep_sel_o[idx]=1.
  - Stream is combinational: ep_t* = rx_t*, with ep_tvalid_o gated by state==RECV; rx_tready = ep_tready_i[idx].
  - rx_done_i -> HSK.
  - rx_err_i -> ep_err_o[idx] pulses the same cycle (combinational, sel still high), then IDLE with no handshake.
- SINK: rx_tready=1, ep_tvalid_o=0, bytes discarded. rx_done_i -> HSK; rx_err_i -> IDLE with no handshake.
- HSK: hsk_send_o=1 with the latched pid; ep_sel_o[idx] stays high if entered from RECV. hsk_done_i -> DONE.
- DONE (one cycle): ep_ack_o[idx]=1 only if entered via RECV with ACK; ep_sel_o[idx] stays high; next state IDLE.
- rx_tready=0 in IDLE, WAIT, HSK and DONE.
- Zero-length packets pass through unchanged (rx_tlast with rx_tkeep=0 is forwarded).

## Timing
- Reset: state IDLE; ep_sel_o, ep_err_o, ep_ack_o, hsk_send_o, busy_o and rx_tready all 0; hsk_pid_o=0; counter=0. Reset mid-transfer clears everything on the next edge, with no ack or error pulse.
- ep_sel_o is registered: high from the cycle after rx_start_i, low on the cycle after DONE or after the rx_err_i cycle. The endpoint therefore sees sel=0 when it returns to idle.
- hsk_send_o rises one cycle after rx_done_i.
- ep_ack_o pulses exactly one cycle after hsk_done_i.
- Simultaneous events:
  - rx_err_i and rx_done_i together: error wins.
  - stall and not-ready together: STALL wins.
  - tok_recv_i while busy_o: ignored.
  - rx_start_i on the TIMEOUT cycle: accepted.
- At most one bit of ep_sel_o, ep_err_o and ep_ack_o is set at any time.

## Test plan
- Token for EP1, DATA0 with ep_par_i=0 and ep_ready=1, 8 bytes -> all 8 bytes forwarded to idx0; hsk_pid_o=0; ep_ack_o=01 one cycle after hsk_done_i; sel drops the next cycle.
- Token for EP2 with ep_ready_i[1]=0 -> bytes sunk, ep_tvalid_o never high, hsk_pid_o=1, no ep_ack_o.
- Token for EP1 with ep_stall_i[0]=1 and ep_ready_i[0]=0 -> hsk_pid_o=2.
- DATA1 received while ep_par_i=0 -> hsk_pid_o=0, ep_sel_o stays 0, ep_ack_o stays 0.
- rx_err_i after 3 bytes -> ep_err_o[0] pulses with ep_sel_o[0] high; no hsk_send_o; IDLE on the next cycle.
- Token for EP5 (out of range) -> busy_o stays 0. In-range token with no rx_start_i -> IDLE after 64 cycles. Reset asserted in HSK -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/usb_bulk_out_sched_if.sv
// Byte-stream bundle between the packet decoder, the OUT scheduler and the endpoints.
//   rx_*        : decoder -> scheduler stream (rx_tready flows back to the decoder)
//   ep_t*_o     : scheduler -> endpoints broadcast stream
//   ep_tready_i : per-endpoint ready, one bit per endpoint index
// modport master: scheduler view; modport slave: decoder/endpoint side view.
interface usb_bulk_out_sched_if #(
   parameter int unsigned NUM_EPS = 2
);
   logic               rx_tvalid;
   logic               rx_tkeep;
   logic               rx_tlast;
   logic [7:0]         rx_tdata;
   logic               rx_tready;
   logic               ep_tvalid_o;
   logic               ep_tkeep_o;
   logic               ep_tlast_o;
   logic [7:0]         ep_tdata_o;
   logic [NUM_EPS-1:0] ep_tready_i;

   modport master (
      input  rx_tvalid, rx_tkeep, rx_tlast, rx_tdata, ep_tready_i,
      output rx_tready, ep_tvalid_o, ep_tkeep_o, ep_tlast_o, ep_tdata_o
   );

   modport slave (
      output rx_tvalid, rx_tkeep, rx_tlast, rx_tdata, ep_tready_i,
      input  rx_tready, ep_tvalid_o, ep_tkeep_o, ep_tlast_o, ep_tdata_o
   );
endinterface

// File: rtl/usb_bulk_out_sched.sv
// Bulk OUT endpoint scheduler: maps an OUT token onto one of NUM_EPS endpoints, routes the
// decoder byte stream to it (or sinks it), checks DATA0/DATA1 parity and requests the
// ACK/NAK/STALL handshake.
//   clock, reset          : clock, synchronous active-high reset
//   tok_recv_i, tok_ep_i  : OUT token pulse and its endpoint number
//   rx_start_i, rx_par_i  : DATAx PID pulse and its parity
//   rx_done_i, rx_err_i   : packet ended good / bad
//   bus_io                : decoder and endpoint byte streams
//   ep_ready_i/stall_i/par_i : per-endpoint status
//   ep_sel_o/err_o/ack_o  : per-endpoint select level, error pulse, ack-sent pulse
//   hsk_send_o, hsk_pid_o, hsk_done_i : handshake request (0=ACK,1=NAK,2=STALL) and completion
//   busy_o                : high whenever not idle
module usb_bulk_out_sched #(
   parameter int unsigned NUM_EPS = 2,
   parameter int unsigned EP_BASE = 1,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 tok_recv_i,
   input  logic [3:0]           tok_ep_i,
   input  logic                 rx_start_i,
   input  logic                 rx_par_i,
   input  logic                 rx_done_i,
   input  logic                 rx_err_i,
   usb_bulk_out_sched_if.master bus_io,
   input  logic [NUM_EPS-1:0]   ep_ready_i,
   input  logic [NUM_EPS-1:0]   ep_stall_i,
   input  logic [NUM_EPS-1:0]   ep_par_i,
   output logic [NUM_EPS-1:0]   ep_sel_o,
   output logic [NUM_EPS-1:0]   ep_err_o,
   output logic [NUM_EPS-1:0]   ep_ack_o,
   output logic                 hsk_send_o,
   output logic [1:0]           hsk_pid_o,
   input  logic                 hsk_done_i,
   output logic                 busy_o
);
   localparam int unsigned IBITS = (NUM_EPS > 1) ? $clog2(NUM_EPS) : 1;
   localparam int unsigned TBITS = $clog2(TIMEOUT + 1);
   localparam logic [TBITS-1:0]   TimeoutCnt = TBITS'(TIMEOUT);
   localparam logic [NUM_EPS-1:0] OneHot0    = NUM_EPS'(1);
   localparam logic [1:0] PidAck   = 2'd0;
   localparam logic [1:0] PidNak   = 2'd1;
   localparam logic [1:0] PidStall = 2'd2;

   typedef enum logic [2:0] {StIdle, StWait, StRecv, StSink, StHsk, StDone} state_e;

   state_e             state_q, state_d;
   logic [IBITS-1:0]   idx_q, idx_d;
   logic [TBITS-1:0]   cnt_q, cnt_d;
   logic [1:0]         pid_q, pid_d;
   logic               ack_q, ack_d;     // transfer went through RECV: endpoint gets sel/ack
   logic [NUM_EPS-1:0] sel_q, sel_d;

   logic [31:0]      tok_ep_ext;
   logic             tok_in_range;
   logic [IBITS-1:0] tok_idx;
   logic             err_pulse;
   logic             ack_pulse;

   assign tok_ep_ext   = {28'd0, tok_ep_i};
   assign tok_in_range = (tok_ep_ext >= EP_BASE) && (tok_ep_ext < EP_BASE + NUM_EPS);
   assign tok_idx      = IBITS'(tok_ep_ext - EP_BASE);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      pid_d     = pid_q;
      ack_d     = ack_q;
      err_pulse = 1'b0;
      ack_pulse = 1'b0;
      hsk_send_o         = 1'b0;
      bus_io.rx_tready   = 1'b0;
      bus_io.ep_tvalid_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (tok_recv_i && tok_in_range) begin
               idx_d   = tok_idx;
               cnt_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            // A DATAx PID on the final timeout cycle still wins over the timeout.
            if (rx_start_i) begin
               ack_d   = 1'b0;
               state_d = StSink;
               if (ep_stall_i[idx_q]) begin
                  pid_d = PidStall;
               end else if (!ep_ready_i[idx_q]) begin
                  pid_d = PidNak;
               end else if (rx_par_i != ep_par_i[idx_q]) begin
                  // Retransmitted packet: ACK it but keep it away from the endpoint.
                  pid_d = PidAck;
               end else begin
                  pid_d   = PidAck;
                  ack_d   = 1'b1;
                  state_d = StRecv;
               end
            end else if (cnt_q == TimeoutCnt) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + TBITS'(1);
            end
         end
         StRecv: begin
            bus_io.rx_tready   = bus_io.ep_tready_i[idx_q];
            bus_io.ep_tvalid_o = bus_io.rx_tvalid;
            if (rx_err_i) begin
               err_pulse = 1'b1;
               state_d   = StIdle;
            end else if (rx_done_i) begin
               state_d = StHsk;
            end
         end
         StSink: begin
            bus_io.rx_tready = 1'b1;
            if (rx_err_i) begin
               state_d = StIdle;
            end else if (rx_done_i) begin
               state_d = StHsk;
            end
         end
         StHsk: begin
            hsk_send_o = 1'b1;
            if (hsk_done_i) begin
               state_d = StDone;
            end
         end
         StDone: begin
            ack_pulse = ack_q;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Select is registered off the next state so it lands the cycle after the decision.
      if ((state_d == StRecv) ||
          (((state_d == StHsk) || (state_d == StDone)) && ack_d)) begin
         sel_d = OneHot0 << idx_d;
      end else begin
         sel_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
         pid_q   <= PidAck;
         ack_q   <= 1'b0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         pid_q   <= pid_d;
         ack_q   <= ack_d;
         sel_q   <= sel_d;
      end
   end

   assign bus_io.ep_tkeep_o = bus_io.rx_tkeep;
   assign bus_io.ep_tlast_o = bus_io.rx_tlast;
   assign bus_io.ep_tdata_o = bus_io.rx_tdata;

   assign ep_sel_o  = sel_q;
   assign ep_err_o  = err_pulse ? (OneHot0 << idx_q) : '0;
   assign ep_ack_o  = ack_pulse ? (OneHot0 << idx_q) : '0;
   assign hsk_pid_o = pid_q;
   assign busy_o    = (state_q != StIdle);
endmodule

// File: tb/tb_usb_bulk_out_sched.sv
// Directed bench for usb_bulk_out_sched (NUM_EPS=2, EP_BASE=1, TIMEOUT=64).
module tb_usb_bulk_out_sched;
   localparam int unsigned NUM_EPS = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       tok_recv_i;
   logic [3:0] tok_ep_i;
   logic       rx_start_i, rx_par_i, rx_done_i, rx_err_i, hsk_done_i;
   logic [1:0] ep_ready_i, ep_stall_i, ep_par_i;
   logic [1:0] ep_sel_o, ep_err_o, ep_ack_o;
   logic       hsk_send_o;
   logic [1:0] hsk_pid_o;
   logic       busy_o;

   usb_bulk_out_sched_if #(.NUM_EPS(NUM_EPS)) bus ();

   usb_bulk_out_sched #(
      .NUM_EPS(NUM_EPS),
      .EP_BASE(1),
      .TIMEOUT(64)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .tok_recv_i (tok_recv_i),
      .tok_ep_i   (tok_ep_i),
      .rx_start_i (rx_start_i),
      .rx_par_i   (rx_par_i),
      .rx_done_i  (rx_done_i),
      .rx_err_i   (rx_err_i),
      .bus_io     (bus),
      .ep_ready_i (ep_ready_i),
      .ep_stall_i (ep_stall_i),
      .ep_par_i   (ep_par_i),
      .ep_sel_o   (ep_sel_o),
      .ep_err_o   (ep_err_o),
      .ep_ack_o   (ep_ack_o),
      .hsk_send_o (hsk_send_o),
      .hsk_pid_o  (hsk_pid_o),
      .hsk_done_i (hsk_done_i),
      .busy_o     (busy_o)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       tok;
      logic [3:0] tep;
      logic       st, par, done, err, hd, tv;
      logic [7:0] td;
      logic [1:0] rdy, stl, epar;
      logic       busy;
      logic [1:0] sel, ack, erro;
      logic       hs;
      logic [1:0] pid;
      logic       rtr, etv;
   } vec_t;

   vec_t vecs[$];
   logic [1:0] cfg_rdy, cfg_stl, cfg_epar;
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs: tok tep st par done err hd tv | expected: busy sel ack erro hs pid rtr etv
   task automatic add(input logic tok, input logic [3:0] tep, input logic st, input logic par,
                      input logic done, input logic err, input logic hd, input logic tv,
                      input logic busy, input logic [1:0] sel, input logic [1:0] ack,
                      input logic [1:0] erro, input logic hs, input logic [1:0] pid,
                      input logic rtr, input logic etv);
      vec_t v;
      v.tok = tok;   v.tep = tep;   v.st = st;   v.par = par;
      v.done = done; v.err = err;   v.hd = hd;   v.tv = tv;
      v.td = 8'(vecs.size() * 7 + 3);
      v.rdy = cfg_rdy; v.stl = cfg_stl; v.epar = cfg_epar;
      v.busy = busy; v.sel = sel;   v.ack = ack; v.erro = erro;
      v.hs = hs;     v.pid = pid;   v.rtr = rtr; v.etv = etv;
      vecs.push_back(v);
   endtask

   task automatic clear_inputs();
      tok_recv_i = 0; tok_ep_i = 0; rx_start_i = 0; rx_par_i = 0;
      rx_done_i = 0; rx_err_i = 0; hsk_done_i = 0;
      bus.rx_tvalid = 0; bus.rx_tkeep = 0; bus.rx_tlast = 0; bus.rx_tdata = 0;
   endtask

   task automatic check_all_zero(input string name);
      check(name, {busy_o, ep_sel_o, ep_ack_o, ep_err_o, hsk_send_o, hsk_pid_o, bus.rx_tready},
            32'd0);
   endtask

   initial begin
      clear_inputs();
      bus.ep_tready_i = 2'b11;
      ep_ready_i = 2'b11; ep_stall_i = 2'b00; ep_par_i = 2'b00;
      reset = 1;
      repeat (2) @(negedge clock);
      check_all_zero("reset_state");
      reset = 0;

      // A: EP1 good DATA0, 8 bytes, second token while busy ignored
      cfg_rdy = 2'b11; cfg_stl = 2'b00; cfg_epar = 2'b00;
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(1, 2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      for (int b = 0; b < 8; b++)
         add(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 1);
      add(0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b01, 2'b00, 2'b00, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      // B: EP2 not ready -> NAK, bytes sunk
      cfg_rdy = 2'b01;
      add(1, 2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      for (int b = 0; b < 3; b++)
         add(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      // C: EP1 stalled and not ready -> STALL
      cfg_rdy = 2'b00; cfg_stl = 2'b01;
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 1, 2, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      // D: DATA1 while DATA0 expected -> ACK, no select, no ack pulse
      cfg_rdy = 2'b11; cfg_stl = 2'b00;
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      // E: rx error after 3 bytes
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      for (int b = 0; b < 3; b++)
         add(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b01, 2'b00, 2'b01, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      // F: error and done together -> error wins
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 1, 0, 0, 1, 2'b01, 2'b00, 2'b01, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      // G: error while sinking -> idle, no handshake
      cfg_rdy = 2'b00;
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      // H: out-of-range tokens (EP5, EP0) ignored
      cfg_rdy = 2'b11;
      add(1, 5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         @(negedge clock);
         tok_recv_i = vecs[i].tok;  tok_ep_i = vecs[i].tep;
         rx_start_i = vecs[i].st;   rx_par_i = vecs[i].par;
         rx_done_i = vecs[i].done;  rx_err_i = vecs[i].err;
         hsk_done_i = vecs[i].hd;
         bus.rx_tvalid = vecs[i].tv; bus.rx_tdata = vecs[i].td;
         ep_ready_i = vecs[i].rdy;  ep_stall_i = vecs[i].stl; ep_par_i = vecs[i].epar;
         #1;
         check($sformatf("vec%0d", i),
               {busy_o, ep_sel_o, ep_ack_o, ep_err_o, hsk_send_o, bus.rx_tready,
                bus.ep_tvalid_o, bus.ep_tdata_o},
               {vecs[i].busy, vecs[i].sel, vecs[i].ack, vecs[i].erro, vecs[i].hs,
                vecs[i].rtr, vecs[i].etv, vecs[i].td});
         if (vecs[i].hs) check($sformatf("vec%0d_pid", i), 32'(hsk_pid_o), 32'(vecs[i].pid));
      end

      // Zero-length packet: tlast with tkeep=0 passes through to EP2
      @(negedge clock);
      clear_inputs();
      ep_ready_i = 2'b11; ep_stall_i = 2'b00; ep_par_i = 2'b10;
      tok_recv_i = 1; tok_ep_i = 2;
      @(negedge clock);
      clear_inputs();
      rx_start_i = 1; rx_par_i = 1;
      @(negedge clock);
      clear_inputs();
      bus.rx_tvalid = 1; bus.rx_tkeep = 0; bus.rx_tlast = 1;
      #1;
      check("zlp_stream", {bus.ep_tvalid_o, bus.ep_tkeep_o, bus.ep_tlast_o, ep_sel_o},
            {1'b1, 1'b0, 1'b1, 2'b10});
      @(negedge clock);
      clear_inputs();
      rx_done_i = 1;
      @(negedge clock);
      clear_inputs();
      hsk_done_i = 1;
      @(negedge clock);
      clear_inputs();
      check("zlp_ack", {ep_ack_o, ep_sel_o, hsk_send_o}, {2'b10, 2'b10, 1'b0});
      @(negedge clock);
      check_all_zero("zlp_idle");

      // Timeout: in-range token, no DATAx PID
      tok_recv_i = 1; tok_ep_i = 1;
      @(negedge clock);
      clear_inputs();
      repeat (62) @(negedge clock);
      check("timeout_still_waiting", {busy_o, hsk_send_o}, 2'b10);
      repeat (4) @(negedge clock);
      check("timeout_idle", {busy_o, hsk_send_o, ep_sel_o}, 4'b0000);

      // Reset while in HSK
      tok_recv_i = 1; tok_ep_i = 1;
      @(negedge clock);
      clear_inputs();
      rx_start_i = 1;
      @(negedge clock);
      clear_inputs();
      rx_done_i = 1;
      @(negedge clock);
      clear_inputs();
      check("pre_reset_hsk", {hsk_send_o, ep_sel_o}, {1'b1, 2'b01});
      reset = 1;
      @(negedge clock);
      check_all_zero("reset_in_hsk");
      reset = 0;
      @(negedge clock);
      check_all_zero("after_reset_in_hsk");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
